flopr_share_arb: RTL and testbench
==================================

Name: flopr_share_arb

Overview:
- Round-robin arbiter and write sequencer that shares one WIDTH-bit synchronous-reset register (flopr-style storage) between N requesters.
- Each requester holds its request while it wants to write. The arbiter grants one owner at a time and loads the owner's data into the shared register every granted cycle.
- Ownership is bounded at HOLD_MAX consecutive writes so no requester can starve the others.
- Sits between the requesting datapath blocks and the shared state register.

Parameters:
- N, 4, number of requesters (≥2)
- WIDTH, 8, width of shared register and of each data lane
- HOLD_MAX, 4, maximum consecutive granted cycles per ownership (≥1)

Ports:
- clk  input  1  system clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- req  input  N  per-requester write request, level-held
- wdata  input  N*WIDTH  lane i = wdata[i*WIDTH +: WIDTH]
- gnt  output  N  one-hot grant, registered; all-zero when idle
- owner  output  $clog2(N)  index of current or last owner
- busy  output  1  high while state is OWN
- q  output  WIDTH  shared register contents
- upd  output  1  one-cycle pulse: q changed at the previous edge

Behaviour:
- Reset (sampled on posedge):
  - gnt=0, owner=0, busy=0, q=0, upd=0.
  - state=IDLE, hold counter cnt=0, priority pointer ptr=0.
  - Reset wins over every other event, including mid-ownership; no write occurs on a reset edge.
- States: IDLE, OWN. busy = (state==OWN). gnt = onehot(owner) when OWN, else 0.
- pick(start): first index i with req[i]=1, searching start, start+1, … mod N. Pure combinational function.
- IDLE:
  - If |req: owner<=pick(ptr), cnt<=0, go to OWN.
  - Else stay in IDLE.
  - Grant latency is 1 cycle (req seen at edge t, gnt high after edge t).
  - No write occurs in IDLE.
- OWN, write rule:
  - A write happens at an edge where req[owner]=1: q<=wdata lane owner, upd<=1.
  - Otherwise no write and upd<=0.
- OWN, owner still requesting and cnt<HOLD_MAX-1:
  - Write; cnt<=cnt+1; stay.
- OWN, owner still requesting and cnt==HOLD_MAX-1 (expiry):
  - Write; ptr<=(owner+1) mod N; owner<=pick((owner+1) mod N); cnt<=0; stay in OWN.
  - Zero-bubble handoff. If the owner is the only requester it is regranted immediately.
- OWN, req[owner]=0 (release):
  - No write; ptr<=(owner+1) mod N.
  - If other requests are pending: owner<=pick((owner+1) mod N), cnt<=0, stay in OWN (zero bubble).
  - Else go to IDLE.
- Data/width rules:
  - wdata is sampled only at write edges.
  - q holds its value otherwise.
  - Requests from non-owners have no effect except in pick.
- owner retains its last value in IDLE.
- Whenever busy=1, gnt is exactly one-hot. gnt is never multi-hot.

Decomposition:
- Package flopr_share_pkg:
  - state_t enum {IDLE, OWN}.
  - Function rr_pick(req, start) returning the index.
  - Localparams for widths: IDXW=$clog2(N), CNTW=$clog2(HOLD_MAX)+1.
- Sub-module flopenr:
  - WIDTH-bit register with synchronous active-high reset and enable.
  - Holds q; enable is the write condition.
  - The arbiter FSM stays in the top module.

Test Plan (N=4, WIDTH=8, HOLD_MAX=4):
- Reset: reset=1 for 2 cycles with req=4'b1111 → gnt=0, q=0, busy=0, upd=0. First edge after reset releases → gnt=4'b0001, owner=0.
- Single requester: req=4'b0100, lane2=8'hA5 → gnt=4'b0100 one cycle later; q=8'hA5 and upd=1 the following cycle. Drop req → gnt=0, busy=0 next cycle; q stays 8'hA5.
- Contention: req=4'b1111 held, lane i=8'h10+i → gnt sequence 0,1,2,3,0, each held 4 cycles with no gap. q follows 8'h10, 8'h11, 8'h12, 8'h13.
- Sole continuous requester: req=4'b0001 → gnt=4'b0001 stays high across the expiry edge. q written every cycle; cnt wraps 0→3→0.
- Early release with pending: owner 1 drops req after 2 writes while req[3]=1 → next cycle gnt=4'b1000 with no idle cycle. No write from lane 1 at the release edge.
- Reset mid-ownership: reset=1 during owner 2's second cycle → next cycle gnt=0, q=0, ptr=0. After reset with req=4'b0110 → grant goes to 1.

Source files
------------

// File: rtl/flopr_share_pkg.sv
// Shared types, default configuration and the round-robin pick function
// for the flopr_share_arb register-sharing arbiter.
package flopr_share_pkg;

  typedef enum logic [0:0] {IDLE, OWN} state_t;

  // Widest request vector rr_pick can scan; real width is passed as n.
  localparam int unsigned NMAX         = 32;
  localparam int unsigned N_DEF        = 4;
  localparam int unsigned WIDTH_DEF    = 8;
  localparam int unsigned HOLD_MAX_DEF = 4;
  localparam int unsigned IDXW         = $clog2(N_DEF);
  localparam int unsigned CNTW         = $clog2(HOLD_MAX_DEF) + 1;

  // First requesting index searching start, start+1, ... mod n.
  // Returns start when nothing is requesting; callers gate on |req.
  function automatic int unsigned rr_pick(input logic [NMAX-1:0] req,
                                          input int unsigned     start,
                                          input int unsigned     n);
    int unsigned idx;
    logic        found;
    rr_pick = start;
    found   = 1'b0;
    for (int unsigned k = 0; k < NMAX; k++) begin
      idx = (start + k) % n;
      if (k < n && !found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/flopr_share_arb_if.sv
// Requester-side bus of the shared register arbiter: level-held requests and
// data lanes in, registered grant/status and the shared register out.
interface flopr_share_arb_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8
) ();
  localparam int unsigned IdxW = $clog2(N);

  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] wdata;
  logic [N-1:0]       gnt;
  logic [IdxW-1:0]    owner;
  logic               busy;
  logic [WIDTH-1:0]   q;
  logic               upd;

  modport master (
    output req, wdata,
    input  gnt, owner, busy, q, upd
  );

  modport slave (
    input  req, wdata,
    output gnt, owner, busy, q, upd
  );
endinterface

// File: rtl/flopenr.sv
// WIDTH-bit register with synchronous active-high reset and load enable.
module flopenr #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/flopr_share_arb.sv
// Round-robin arbiter sharing one register among N requesters, with ownership
// bounded to HOLD_MAX consecutive writes and zero-bubble handoff.
module flopr_share_arb
  import flopr_share_pkg::*;
#(
  parameter int unsigned N        = N_DEF,
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned HOLD_MAX = HOLD_MAX_DEF
) (
  input logic               clk,
  input logic               reset,
  flopr_share_arb_if.slave  bus
);
  localparam int unsigned IdxW = $clog2(N);
  localparam int unsigned CntW = $clog2(HOLD_MAX) + 1;

  state_t            state_q;
  logic [IdxW-1:0]   owner_q, ptr_q;
  logic [CntW-1:0]   cnt_q;
  logic [N-1:0]      gnt_q;
  logic              upd_q;

  logic [NMAX-1:0]   req_ext;
  logic [IdxW-1:0]   owner_inc, pick_ptr, pick_nxt;
  logic [N-1:0]      gnt_ptr, gnt_nxt;
  logic              any_req, owner_req, we;
  logic [WIDTH-1:0]  wdata_sel, q_reg;

  always_comb begin
    req_ext          = '0;
    req_ext[N-1:0]   = bus.req;
    owner_inc        = (owner_q == IdxW'(N - 1)) ? '0 : owner_q + 1'b1;
    pick_ptr         = IdxW'(rr_pick(req_ext, 32'(ptr_q), N));
    pick_nxt         = IdxW'(rr_pick(req_ext, 32'(owner_inc), N));
    gnt_ptr          = '0;
    gnt_ptr[pick_ptr] = 1'b1;
    gnt_nxt          = '0;
    gnt_nxt[pick_nxt] = 1'b1;
    any_req          = |bus.req;
    owner_req        = bus.req[owner_q];
    we               = (state_q == OWN) && owner_req;
    wdata_sel        = bus.wdata[owner_q*WIDTH +: WIDTH];
  end

  flopenr #(
    .WIDTH (WIDTH)
  ) u_flopenr (
    .clk   (clk),
    .reset (reset),
    .en    (we),
    .d     (wdata_sel),
    .q     (q_reg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      upd_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          upd_q <= 1'b0;
          if (any_req) begin
            owner_q <= pick_ptr;
            gnt_q   <= gnt_ptr;
            cnt_q   <= '0;
            state_q <= OWN;
          end
        end
        OWN: begin
          if (owner_req) begin
            upd_q <= 1'b1;
            if (cnt_q == CntW'(HOLD_MAX - 1)) begin
              // Expiry: hand off, or regrant if the owner is alone.
              ptr_q   <= owner_inc;
              owner_q <= pick_nxt;
              gnt_q   <= gnt_nxt;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            upd_q <= 1'b0;
            ptr_q <= owner_inc;
            if (any_req) begin
              owner_q <= pick_nxt;
              gnt_q   <= gnt_nxt;
              cnt_q   <= '0;
            end else begin
              gnt_q   <= '0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.owner = owner_q;
  assign bus.busy  = (state_q == OWN);
  assign bus.q     = q_reg;
  assign bus.upd   = upd_q;

endmodule

// File: tb/tb_flopr_share_arb.sv
// Directed bench for flopr_share_arb (N=4, WIDTH=8, HOLD_MAX=4) with
// hand-computed expected grant, owner and register values.
module tb_flopr_share_arb;
  logic clk;
  logic reset;
  logic [7:0] lane [4];

  int checks;
  int failures;

  flopr_share_arb_if #(.N(4), .WIDTH(8)) bus ();

  assign bus.wdata = {lane[3], lane[2], lane[1], lane[0]};

  flopr_share_arb #(
    .N        (4),
    .WIDTH    (8),
    .HOLD_MAX (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_gnt;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.req  = 4'b1111;
    for (int i = 0; i < 4; i++) lane[i] = 8'h10 + 8'(i);

    // Reset held two cycles with all requesting
    tick();
    tick();
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    check("rst_q", 32'(bus.q), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_upd", 32'(bus.upd), 32'h0);
    reset = 1'b0;
    tick();
    check("first_gnt", 32'(bus.gnt), 32'h1);
    check("first_owner", 32'(bus.owner), 32'h0);
    check("first_busy", 32'(bus.busy), 32'h1);
    check("first_upd", 32'(bus.upd), 32'h0);

    // Contention: owners 0,1,2,3,0 each for four writes, no gaps
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 4; k++) begin
        tick();
        exp_gnt = (k < 3) ? 4'(1 << g) : 4'(1 << ((g + 1) % 4));
        check("cont_gnt", 32'(bus.gnt), 32'(exp_gnt));
        check("cont_q", 32'(bus.q), 32'h10 + 32'(g));
        check("cont_upd", 32'(bus.upd), 32'h1);
      end
    end
    check("cont_owner_wrap", 32'(bus.owner), 32'h0);

    // Sole continuous requester: regranted across expiry, written every cycle
    bus.req = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      lane[0] = 8'h20 + 8'(k);
      tick();
      check("sole_gnt", 32'(bus.gnt), 32'h1);
      check("sole_q", 32'(bus.q), 32'h20 + 32'(k));
      check("sole_upd", 32'(bus.upd), 32'h1);
    end

    // Single requester on lane 2
    bus.req = 4'b0100;
    lane[2] = 8'hA5;
    tick();
    check("single_gnt", 32'(bus.gnt), 32'h4);
    check("single_nowrite_q", 32'(bus.q), 32'h27);
    check("single_nowrite_upd", 32'(bus.upd), 32'h0);
    tick();
    check("single_q", 32'(bus.q), 32'hA5);
    check("single_upd", 32'(bus.upd), 32'h1);
    bus.req = 4'b0000;
    tick();
    check("drop_gnt", 32'(bus.gnt), 32'h0);
    check("drop_busy", 32'(bus.busy), 32'h0);
    check("drop_upd", 32'(bus.upd), 32'h0);
    check("drop_q", 32'(bus.q), 32'hA5);
    tick();
    check("idle_q", 32'(bus.q), 32'hA5);
    check("idle_owner", 32'(bus.owner), 32'h2);

    // Early release by owner 1 with requester 3 pending (ptr is now 3)
    bus.req = 4'b0010;
    tick();
    check("er_gnt1", 32'(bus.gnt), 32'h2);
    check("er_owner1", 32'(bus.owner), 32'h1);
    bus.req = 4'b1010;
    lane[1] = 8'h55;
    lane[3] = 8'h77;
    tick();
    tick();
    check("er_q1", 32'(bus.q), 32'h55);
    check("er_gnt_hold", 32'(bus.gnt), 32'h2);
    bus.req = 4'b1000;
    lane[1] = 8'hEE;
    tick();
    check("er_gnt3", 32'(bus.gnt), 32'h8);
    check("er_busy", 32'(bus.busy), 32'h1);
    check("er_nowrite_q", 32'(bus.q), 32'h55);
    check("er_nowrite_upd", 32'(bus.upd), 32'h0);
    tick();
    check("er_q3", 32'(bus.q), 32'h77);

    // Reset during owner 2's second cycle
    bus.req = 4'b0100;
    lane[2] = 8'h3C;
    tick();
    check("mr_gnt2", 32'(bus.gnt), 32'h4);
    tick();
    check("mr_q2", 32'(bus.q), 32'h3C);
    reset = 1'b1;
    tick();
    check("mr_gnt", 32'(bus.gnt), 32'h0);
    check("mr_q", 32'(bus.q), 32'h0);
    check("mr_busy", 32'(bus.busy), 32'h0);
    check("mr_upd", 32'(bus.upd), 32'h0);
    check("mr_owner", 32'(bus.owner), 32'h0);
    reset   = 1'b0;
    bus.req = 4'b0110;
    tick();
    check("post_gnt", 32'(bus.gnt), 32'h2);
    check("post_owner", 32'(bus.owner), 32'h1);
    check("post_q", 32'(bus.q), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
